// File: rtl/v_pipe_issue_ctrl.sv
// Issue controller in front of the update pipeline: skid-buffers commands, issues
// one per cycle, blocks same-key RAW hazards and drains before CLEAR. Macro V_ISSUE_STATS_EN adds issue/stall counters.
package v_pkg;
  typedef enum logic [1:0] {
    CMD_NOP   = 2'd0,
    CMD_ADD   = 2'd1,
    CMD_SUB   = 2'd2,
    CMD_CLEAR = 2'd3
  } cmd_t;
  typedef logic [7:0]  key_t;
  typedef logic [15:0] volume_t;
endpackage

module v_pipe_issue_ctrl
  import v_pkg::*;
#(
  parameter int PIPE_DEPTH = 3,
  parameter int BUF_N      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  // Upstream: a transfer happens on any clock edge where i_cmd_vld & o_cmd_rdy;
  // o_cmd_rdy depends only on buffer occupancy, never on i_cmd_vld.
  input  logic        i_cmd_vld,
  input  cmd_t        i_cmd,
  input  key_t        i_key,
  input  volume_t     i_volume,
  output logic        o_cmd_rdy,
  output logic        o_pipe_vld_r,
  output cmd_t        o_pipe_cmd_r,
  output key_t        o_pipe_key_r,
  output volume_t     o_pipe_vol_r,
  output logic        o_busy_r,
  output logic [0:0]  dbg_state
`ifdef V_ISSUE_STATS_EN
  ,
  output logic [31:0] o_stat_issue_r,
  output logic [31:0] o_stat_stall_r
`endif
);

  localparam int PW = $clog2(BUF_N);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(BUF_N);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  cmd_t    cmd_mem [BUF_N];
  key_t    key_mem [BUF_N];
  volume_t vol_mem [BUF_N];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count, count_nxt;
  logic          push, pop, issue;
  logic          head_vld, hz, live;
  cmd_t          head_cmd;
  key_t          head_key;
  volume_t       head_vol;
  logic [0:0]    state, state_nxt;

  logic [PIPE_DEPTH-1:0] win_vld, win_vld_nxt;
  key_t                  win_key [PIPE_DEPTH];

  assign o_cmd_rdy = (count != CNT_FULL);
  assign push      = i_cmd_vld & o_cmd_rdy;
  assign head_vld  = (count != '0);
  assign head_cmd  = cmd_mem[rd_ptr];
  assign head_key  = key_mem[rd_ptr];
  assign head_vol  = vol_mem[rd_ptr];
  assign dbg_state = state;

  // The oldest slot writes back on this edge, so only younger slots can still
  // hold stale state for a command issuing now.
  always_comb begin
    hz   = 1'b0;
    live = 1'b0;
    for (int i = 0; i < PIPE_DEPTH-1; i++) begin
      if (win_vld[i]) begin
        live = 1'b1;
        if (win_key[i] == head_key) hz = 1'b1;
      end
    end
  end

  always_comb begin
    issue     = 1'b0;
    pop       = 1'b0;
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (head_vld) begin
          if (head_cmd == CMD_NOP) begin
            pop = 1'b1;
          end else if (head_cmd == CMD_CLEAR) begin
            if (live) begin
              state_nxt = ST_DRAIN;
            end else begin
              issue = 1'b1;
              pop   = 1'b1;
            end
          end else if (!hz) begin
            issue = 1'b1;
            pop   = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (head_vld && !live) begin
          issue     = 1'b1;
          pop       = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CNT_ONE;
    else if (!push && pop) count_nxt = count - CNT_ONE;
  end

  assign win_vld_nxt = {win_vld[PIPE_DEPTH-2:0], issue};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      state        <= ST_RUN;
      win_vld      <= '0;
      o_pipe_vld_r <= 1'b0;
      o_pipe_cmd_r <= CMD_NOP;
      o_pipe_key_r <= '0;
      o_pipe_vol_r <= '0;
      o_busy_r     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count        <= count_nxt;
      state        <= state_nxt;
      win_vld      <= win_vld_nxt;
      o_pipe_vld_r <= issue;
      if (issue) begin
        o_pipe_cmd_r <= head_cmd;
        o_pipe_key_r <= head_key;
        o_pipe_vol_r <= head_vol;
      end
      o_busy_r <= (count_nxt != '0) | (|win_vld_nxt);
    end
  end

  // Payload storage needs no reset: occupancy and window valids gate every use.
  always_ff @(posedge clk) begin
    if (push) begin
      cmd_mem[wr_ptr] <= i_cmd;
      key_mem[wr_ptr] <= i_key;
      vol_mem[wr_ptr] <= i_volume;
    end
    win_key[0] <= head_key;
    for (int i = 1; i < PIPE_DEPTH; i++) win_key[i] <= win_key[i-1];
  end

`ifdef V_ISSUE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_stat_issue_r <= '0;
      o_stat_stall_r <= '0;
    end else begin
      if (issue && (o_stat_issue_r != 32'hFFFF_FFFF))
        o_stat_issue_r <= o_stat_issue_r + 32'd1;
      if (head_vld && !pop && (o_stat_stall_r != 32'hFFFF_FFFF))
        o_stat_stall_r <= o_stat_stall_r + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_v_pipe_issue_ctrl.sv
// Bench for v_pipe_issue_ctrl: directed scenarios plus random traffic, checked
// against a queue-based reference model (issue cycle and key history).
module tb_v_pipe_issue_ctrl;
  import v_pkg::*;

  localparam int PD    = 3;
  localparam int BUF_N = 2;

  typedef struct packed {
    cmd_t    cmd;
    key_t    key;
    volume_t vol;
  } ent_t;
  localparam int W = $bits(ent_t);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       drv_vld = 1'b0;
  cmd_t       drv_cmd = CMD_NOP;
  key_t       drv_key = '0;
  volume_t    drv_vol = '0;
  logic       o_cmd_rdy, o_pipe_vld_r, o_busy_r;
  cmd_t       o_pipe_cmd_r;
  key_t       o_pipe_key_r;
  volume_t    o_pipe_vol_r;
  logic [0:0] dbg_state;
`ifdef V_ISSUE_STATS_EN
  logic [31:0] o_stat_issue_r, o_stat_stall_r;
  int          m_issue, m_stall;
`endif

  v_pipe_issue_ctrl #(.PIPE_DEPTH(PD), .BUF_N(BUF_N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_cmd_vld    (drv_vld),
    .i_cmd        (drv_cmd),
    .i_key        (drv_key),
    .i_volume     (drv_vol),
    .o_cmd_rdy    (o_cmd_rdy),
    .o_pipe_vld_r (o_pipe_vld_r),
    .o_pipe_cmd_r (o_pipe_cmd_r),
    .o_pipe_key_r (o_pipe_key_r),
    .o_pipe_vol_r (o_pipe_vol_r),
    .o_busy_r     (o_busy_r),
    .dbg_state    (dbg_state)
`ifdef V_ISSUE_STATS_EN
    ,
    .o_stat_issue_r (o_stat_issue_r),
    .o_stat_stall_r (o_stat_stall_r)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model and scoreboard
  ent_t          pend_q[$];
  int            iss_cyc_q[$];
  key_t          iss_key_q[$];
  logic [W-1:0]  exp_q[$];
  int            iss_hist[$];
  int            cyc = 0;
  bit            last_acc = 0;
  int            n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // A command may issue at edge e unless something it depends on was issued
  // fewer than PD edges earlier (CLEAR depends on everything).
  function automatic bit may_issue(input ent_t h, input int e);
    for (int i = 0; i < iss_cyc_q.size(); i++)
      if ((e - iss_cyc_q[i] < PD) && (h.cmd == CMD_CLEAR || iss_key_q[i] == h.key))
        return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick();
    bit   exp_rdy, acc, pop, iss, drain;
    ent_t h, in_e, got;
    exp_rdy = (pend_q.size() < BUF_N);
    if (rst_n) chk("cmd_rdy", {31'd0, o_cmd_rdy}, {31'd0, exp_rdy});
    acc   = drv_vld && exp_rdy;
    pop   = 0;
    iss   = 0;
    drain = 0;
    h     = '0;
    if (pend_q.size() != 0) begin
      h = pend_q[0];
      if (h.cmd == CMD_NOP) pop = 1;
      else if (may_issue(h, cyc + 1)) begin pop = 1; iss = 1; end
      else if (h.cmd == CMD_CLEAR) drain = 1;
    end
    in_e.cmd = drv_cmd;
    in_e.key = drv_key;
    in_e.vol = drv_vol;
    @(posedge clk);
    cyc++;
    last_acc = acc && rst_n;
    if (!rst_n) begin
      pend_q.delete();
      iss_cyc_q.delete();
      iss_key_q.delete();
      exp_q.delete();
      iss = 0;
      drain = 0;
`ifdef V_ISSUE_STATS_EN
      m_issue = 0;
      m_stall = 0;
`endif
    end else begin
`ifdef V_ISSUE_STATS_EN
      if (iss) m_issue++;
      if (pend_q.size() != 0 && !pop) m_stall++;
`endif
      if (pop) pend_q.delete(0);
      if (acc) pend_q.push_back(in_e);
      if (iss) begin
        iss_cyc_q.push_back(cyc);
        iss_key_q.push_back(h.key);
        exp_q.push_back(h);
        iss_hist.push_back(cyc);
      end
      while (iss_cyc_q.size() != 0 && (cyc - iss_cyc_q[0] >= PD)) begin
        iss_cyc_q.delete(0);
        iss_key_q.delete(0);
      end
    end
    #1;
    chk("pipe_vld", {31'd0, o_pipe_vld_r}, {31'd0, iss});
    if (iss) begin
      got = ent_t'(exp_q.pop_front());
      chk("pipe_cmd", {30'd0, o_pipe_cmd_r}, {30'd0, got.cmd});
      chk("pipe_key", {24'd0, o_pipe_key_r}, {24'd0, got.key});
      chk("pipe_vol", {16'd0, o_pipe_vol_r}, {16'd0, got.vol});
    end
    chk("busy", {31'd0, o_busy_r},
        {31'd0, (pend_q.size() != 0) || (iss_cyc_q.size() != 0)});
    chk("fsm_drain", {31'd0, dbg_state}, {31'd0, drain});
  endtask

  // driver tasks
  task automatic idle(input int n);
    drv_vld = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_hold(input cmd_t c, input key_t k, input volume_t v);
    int tries;
    drv_vld = 1'b1;
    drv_cmd = c;
    drv_key = k;
    drv_vol = v;
    tries   = 0;
    do begin
      tick();
      tries++;
    end while (!last_acc && tries < 20);
    chk("push_accept", {31'd0, last_acc}, 32'd1);
    drv_vld = 1'b0;
  endtask

  initial begin : main
    int t, r;

    // reset: two cycles low
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    chk("rst_cmd", {30'd0, o_pipe_cmd_r}, 32'd0);
    chk("rst_key", {24'd0, o_pipe_key_r}, 32'd0);
    chk("rst_vol", {16'd0, o_pipe_vol_r}, 32'd0);
    chk("rst_rdy", {31'd0, o_cmd_rdy}, 32'd1);

    // distinct keys issue on consecutive cycles, one cycle after accept
    iss_hist.delete();
    t = cyc + 1;
    push_hold(CMD_ADD, 8'd1, 16'h0101);
    push_hold(CMD_SUB, 8'd2, 16'h0202);
    push_hold(CMD_ADD, 8'd3, 16'h0303);
    idle(4);
    chk("distinct_n", iss_hist.size(), 32'd3);
    for (int i = 0; i < 3 && i < iss_hist.size(); i++)
      chk("distinct_lat", iss_hist[i] - t, i + 1);

    // same key back-to-back: second waits out the pipe depth
    iss_hist.delete();
    t = cyc + 1;
    push_hold(CMD_ADD, 8'd5, 16'h0005);
    push_hold(CMD_ADD, 8'd5, 16'h0050);
    idle(6);
    chk("same_n", iss_hist.size(), 32'd2);
    if (iss_hist.size() == 2) begin
      chk("same_first", iss_hist[0] - t, 32'd1);
      chk("same_second", iss_hist[1] - t, 32'd4);
    end

    // CLEAR drains the window first
    iss_hist.delete();
    t = cyc + 1;
    push_hold(CMD_ADD, 8'd7, 16'h0777);
    push_hold(CMD_CLEAR, 8'd7, 16'h0000);
    tick();
    chk("drain_enter", {31'd0, dbg_state}, 32'd1);
    idle(4);
    chk("clear_n", iss_hist.size(), 32'd2);
    if (iss_hist.size() == 2) chk("clear_time", iss_hist[1] - t, 32'd4);
    chk("drain_exit", {31'd0, dbg_state}, 32'd0);

    // buffer fills behind a hazard; NOP head is dropped silently
    iss_hist.delete();
    push_hold(CMD_ADD, 8'd9, 16'h0901);
    push_hold(CMD_SUB, 8'd9, 16'h0902);
    push_hold(CMD_ADD, 8'd9, 16'h0903);
    chk("full_rdy", {31'd0, o_cmd_rdy}, 32'd0);
    push_hold(CMD_NOP, 8'd9, 16'h0904);
    push_hold(CMD_ADD, 8'd4, 16'h0401);
    idle(10);
    chk("full_issued", iss_hist.size(), 32'd4);
    chk("full_sb_empty", exp_q.size(), 32'd0);

    // reset with two buffered and two in flight
    push_hold(CMD_ADD, 8'd1, 16'h1001);
    push_hold(CMD_ADD, 8'd2, 16'h1002);
    push_hold(CMD_SUB, 8'd2, 16'h1003);
    push_hold(CMD_ADD, 8'd2, 16'h1004);
    chk("pre_rst_full", {31'd0, o_cmd_rdy}, 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_busy", {31'd0, o_busy_r}, 32'd0);
    iss_hist.delete();
    idle(6);
    chk("no_stale_issue", iss_hist.size(), 32'd0);

    // random traffic; valid is held stable until accepted
    for (int n = 0; n < 1500; n++) begin
      if (!drv_vld || last_acc) begin
        drv_vld = ($urandom_range(0, 99) < 60);
        r = $urandom_range(0, 9);
        if (r == 0)      drv_cmd = CMD_NOP;
        else if (r == 1) drv_cmd = CMD_CLEAR;
        else if (r < 6)  drv_cmd = CMD_ADD;
        else             drv_cmd = CMD_SUB;
        drv_key = key_t'($urandom_range(0, 3));
        drv_vol = volume_t'($urandom);
      end
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1'b1;
    idle(12);
    chk("final_sb_empty", exp_q.size(), 32'd0);
    chk("final_busy", {31'd0, o_busy_r}, 32'd0);
`ifdef V_ISSUE_STATS_EN
    chk("stat_issue", o_stat_issue_r, m_issue);
    chk("stat_stall", o_stat_stall_r, m_stall);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
